// File: rtl/hps_frame_ctrl_if.sv
// rtl/hps_frame_ctrl_if.sv - HPS frame sequencer signal bundle (enables, rx word stream, channel replies, outputs)
interface hps_frame_ctrl_if #(
    parameter int IDX_W = 12
);
    logic              io_en;
    logic              osd_en;
    logic              fpga_en;
    logic [15:0]       rx_word;
    logic              rx_strobe;
    logic [15:0]       reply_io;
    logic [15:0]       reply_osd;
    logic [15:0]       reply_fpga;
    logic [15:0]       tx_word;
    logic [1:0]        ch_sel;
    logic [15:0]       cmd;
    logic              cmd_strobe;
    logic [15:0]       data;
    logic              data_strobe;
    logic [IDX_W-1:0]  word_idx;
    logic              frame_end;
    logic              conflict;
    logic              timeout;

    modport master (
        input  io_en, osd_en, fpga_en, rx_word, rx_strobe,
        input  reply_io, reply_osd, reply_fpga,
        output tx_word, ch_sel, cmd, cmd_strobe, data, data_strobe,
        output word_idx, frame_end, conflict, timeout
    );

    modport slave (
        output io_en, osd_en, fpga_en, rx_word, rx_strobe,
        output reply_io, reply_osd, reply_fpga,
        input  tx_word, ch_sel, cmd, cmd_strobe, data, data_strobe,
        input  word_idx, frame_end, conflict, timeout
    );
endinterface

// File: rtl/hps_frame_ctrl.sv
// rtl/hps_frame_ctrl.sv - frames HPS SPI word transfers into command/data words and routes channel replies
module hps_frame_ctrl #(
    parameter int IDX_W   = 12,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_sys,
    input  logic              reset,
    hps_frame_ctrl_if.master  bus
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

    localparam int                WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]   TO_VAL  = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  IDX_MAX = '1;

    state_t            state, state_nxt;
    logic [1:0]        ch_sel_q, ch_sel_nxt;
    logic [15:0]       tx_q, tx_nxt;
    logic [15:0]       cmd_q, cmd_nxt;
    logic [15:0]       data_q, data_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [IDX_W-1:0]  cnt_q, cnt_nxt;
    logic [WD_W-1:0]   wd_q, wd_nxt, wd_inc;
    logic              cmd_stb_nxt, data_stb_nxt, fend_nxt, conf_nxt, tmo_nxt;
    logic              cmd_stb_q, data_stb_q, fend_q, conf_q, tmo_q;

    logic [2:0]        en;
    logic [2:0]        sel_mask;
    logic              multi, sel_en, other_en, expire;
    logic [1:0]        first_ch;
    logic [15:0]       sel_reply;

    assign en       = {bus.fpga_en, bus.osd_en, bus.io_en};
    assign multi    = (en & (en - 3'd1)) != 3'd0;
    assign first_ch = en[0] ? 2'd1 : (en[1] ? 2'd2 : 2'd3);

    always_comb begin
        sel_mask  = 3'b000;
        sel_reply = 16'h0000;
        case (ch_sel_q)
            2'd1:    begin sel_mask = 3'b001; sel_reply = bus.reply_io;   end
            2'd2:    begin sel_mask = 3'b010; sel_reply = bus.reply_osd;  end
            2'd3:    begin sel_mask = 3'b100; sel_reply = bus.reply_fpga; end
            default: begin sel_mask = 3'b000; sel_reply = 16'h0000;       end
        endcase
    end

    assign sel_en   = |(en & sel_mask);
    assign other_en = |(en & ~sel_mask);
    assign wd_inc   = wd_q + 1'b1;
    assign expire   = (TIMEOUT != 0) && (wd_inc == TO_VAL);

    always_comb begin
        state_nxt    = state;
        ch_sel_nxt   = ch_sel_q;
        tx_nxt       = 16'h0000;
        cmd_nxt      = cmd_q;
        data_nxt     = data_q;
        idx_nxt      = idx_q;
        cnt_nxt      = cnt_q;
        wd_nxt       = wd_q;
        cmd_stb_nxt  = 1'b0;
        data_stb_nxt = 1'b0;
        fend_nxt     = 1'b0;
        conf_nxt     = 1'b0;
        tmo_nxt      = 1'b0;

        case (state)
            IDLE: begin
                wd_nxt     = '0;
                ch_sel_nxt = 2'd0;
                if (multi) begin
                    state_nxt = DRAIN;
                    conf_nxt  = 1'b1;
                end else if (en != 3'b000) begin
                    state_nxt  = CMD;
                    ch_sel_nxt = first_ch;
                end
            end

            CMD, DATA: begin
                wd_nxt = (bus.rx_strobe || TIMEOUT == 0) ? '0 : wd_inc;
                if (other_en) begin
                    state_nxt  = DRAIN;
                    ch_sel_nxt = 2'd0;
                    conf_nxt   = 1'b1;
                end else if (expire) begin
                    state_nxt  = DRAIN;
                    ch_sel_nxt = 2'd0;
                    tmo_nxt    = 1'b1;
                end else begin
                    if (bus.rx_strobe) begin
                        if (state == CMD) begin
                            cmd_nxt     = bus.rx_word;
                            cmd_stb_nxt = 1'b1;
                            cnt_nxt     = '0;
                            state_nxt   = DATA;
                        end else begin
                            data_nxt     = bus.rx_word;
                            idx_nxt      = cnt_q;
                            data_stb_nxt = 1'b1;
                            cnt_nxt      = (cnt_q == IDX_MAX) ? cnt_q : cnt_q + 1'b1;
                        end
                    end
                    // A word arriving with the enable fall still belongs to the frame.
                    if (!sel_en) begin
                        state_nxt  = IDLE;
                        ch_sel_nxt = 2'd0;
                        fend_nxt   = 1'b1;
                    end
                    if (state_nxt == CMD || state_nxt == DATA)
                        tx_nxt = sel_reply;
                end
            end

            DRAIN: begin
                ch_sel_nxt = 2'd0;
                wd_nxt     = '0;
                if (en == 3'b000)
                    state_nxt = IDLE;
            end

            default: begin
                state_nxt  = IDLE;
                ch_sel_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ch_sel_q   <= 2'd0;
            tx_q       <= 16'h0000;
            cmd_q      <= 16'h0000;
            data_q     <= 16'h0000;
            idx_q      <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            cmd_stb_q  <= 1'b0;
            data_stb_q <= 1'b0;
            fend_q     <= 1'b0;
            conf_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ch_sel_q   <= ch_sel_nxt;
            tx_q       <= tx_nxt;
            cmd_q      <= cmd_nxt;
            data_q     <= data_nxt;
            idx_q      <= idx_nxt;
            cnt_q      <= cnt_nxt;
            wd_q       <= wd_nxt;
            cmd_stb_q  <= cmd_stb_nxt;
            data_stb_q <= data_stb_nxt;
            fend_q     <= fend_nxt;
            conf_q     <= conf_nxt;
            tmo_q      <= tmo_nxt;
        end
    end

    assign bus.tx_word     = tx_q;
    assign bus.ch_sel      = ch_sel_q;
    assign bus.cmd         = cmd_q;
    assign bus.cmd_strobe  = cmd_stb_q;
    assign bus.data        = data_q;
    assign bus.data_strobe = data_stb_q;
    assign bus.word_idx    = idx_q;
    assign bus.frame_end   = fend_q;
    assign bus.conflict    = conf_q;
    assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_hps_frame_ctrl.sv
// tb/tb_hps_frame_ctrl.sv - directed bench for hps_frame_ctrl with IDX_W=2, TIMEOUT=8
module tb_hps_frame_ctrl;

    logic clk_sys = 1'b0;
    logic reset   = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk_sys = ~clk_sys;

    hps_frame_ctrl_if #(.IDX_W(2)) bus ();

    hps_frame_ctrl #(.IDX_W(2), .TIMEOUT(8)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bus.rx_word   = w;
        bus.rx_strobe = 1'b1;
        tick();
        bus.rx_strobe = 1'b0;
    endtask

    logic [1:0] exp_idx [6];

    initial begin
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.io_en = 0; bus.osd_en = 0; bus.fpga_en = 0;
        bus.rx_word = 0; bus.rx_strobe = 0;
        bus.reply_io = 16'h0000; bus.reply_osd = 16'h0BEE; bus.reply_fpga = 16'h0000;
        repeat (3) tick();
        check("rst_ch_sel", bus.ch_sel, 0);
        check("rst_tx", bus.tx_word, 0);
        check("rst_cmd", bus.cmd, 0);
        check("rst_strobes", {bus.cmd_strobe, bus.data_strobe, bus.frame_end, bus.conflict, bus.timeout}, 0);
        reset = 1'b1;
        tick();

        // osd frame: command plus two data words
        bus.osd_en = 1; tick();
        check("osd_ch_sel", bus.ch_sel, 2);
        send(16'h0014);
        check("osd_cmd_stb", bus.cmd_strobe, 1);
        check("osd_cmd", bus.cmd, 16'h0014);
        check("osd_tx", bus.tx_word, 16'h0BEE);
        send(16'hAAAA);
        check("osd_d0", {bus.data_strobe, bus.word_idx, bus.data}, {1'b1, 2'd0, 16'hAAAA});
        check("osd_cmd_stb_low", bus.cmd_strobe, 0);
        send(16'h5555);
        check("osd_d1", {bus.data_strobe, bus.word_idx, bus.data}, {1'b1, 2'd1, 16'h5555});
        bus.osd_en = 0; tick();
        check("osd_fend", {bus.frame_end, bus.ch_sel, bus.tx_word}, {1'b1, 2'd0, 16'h0000});
        tick();
        check("osd_fend_pulse", bus.frame_end, 0);

        // io frame: tx_word follows only reply_io
        bus.reply_io = 16'h1234; bus.reply_osd = 16'h1111; bus.reply_fpga = 16'h2222;
        bus.io_en = 1; tick();
        check("io_ch_sel", bus.ch_sel, 1);
        check("io_tx_lat", bus.tx_word, 0);
        tick();
        check("io_tx", bus.tx_word, 16'h1234);
        bus.reply_osd = 16'h7777; bus.reply_fpga = 16'h8888; tick();
        check("io_tx_other", bus.tx_word, 16'h1234);
        bus.reply_io = 16'h4321; tick();
        check("io_tx_follow", bus.tx_word, 16'h4321);
        send(16'h0001);
        bus.io_en = 0; tick();
        check("io_idle_tx", {bus.frame_end, bus.tx_word}, {1'b1, 16'h0000});
        tick();

        // simultaneous enables -> conflict, drain, recovery
        bus.fpga_en = 1; bus.io_en = 1; tick();
        check("conf_pulse", {bus.conflict, bus.ch_sel}, {1'b1, 2'd0});
        send(16'h00AB);
        check("conf_no_cmd", {bus.cmd_strobe, bus.conflict}, 0);
        send(16'h00CD);
        check("conf_cmd_hold", bus.cmd, 16'h0001);
        bus.fpga_en = 0; bus.io_en = 0; tick();
        check("conf_no_fend", bus.frame_end, 0);
        bus.fpga_en = 1; tick();
        check("fpga_ch_sel", bus.ch_sel, 3);
        send(16'h0033);
        check("fpga_cmd", {bus.cmd_strobe, bus.cmd}, {1'b1, 16'h0033});
        send(16'h0044);
        check("fpga_d0", {bus.data_strobe, bus.data}, {1'b1, 16'h0044});
        bus.osd_en = 1; bus.rx_word = 16'h0055; bus.rx_strobe = 1; tick();
        bus.rx_strobe = 0;
        check("mid_conf", {bus.conflict, bus.data_strobe, bus.ch_sel, bus.data}, {1'b1, 1'b0, 2'd0, 16'h0044});
        bus.osd_en = 0; bus.fpga_en = 0; tick();
        check("mid_conf_nofe", bus.frame_end, 0);
        tick();

        // watchdog expiry after the last data word
        bus.io_en = 1; tick();
        send(16'h0007);
        send(16'h0099);
        repeat (7) tick();
        check("wd_early", bus.timeout, 0);
        tick();
        check("wd_pulse", {bus.timeout, bus.ch_sel}, {1'b1, 2'd0});
        send(16'h00EE);
        check("wd_no_data", {bus.data_strobe, bus.data}, {1'b0, 16'h0099});
        bus.io_en = 0; tick();
        check("wd_no_fend", bus.frame_end, 0);
        tick();

        // index saturation, last word coincident with enable fall
        bus.io_en = 1; tick();
        send(16'h0100);
        for (int i = 0; i < 5; i++) begin
            send(16'h0A00 + 16'(i));
            check($sformatf("sat_idx%0d", i), {bus.data_strobe, bus.word_idx}, {1'b1, exp_idx[i]});
        end
        bus.rx_word = 16'h0AFF; bus.rx_strobe = 1; bus.io_en = 0; tick();
        bus.rx_strobe = 0;
        check("sat_last", {bus.data_strobe, bus.frame_end, bus.word_idx, bus.data}, {1'b1, 1'b1, exp_idx[5], 16'h0AFF});
        tick();

        // asynchronous reset mid-frame, restart with enable held
        bus.io_en = 1; tick();
        send(16'h0200);
        send(16'h0300);
        #3 reset = 0;
        #1;
        check("arst_regs", {bus.cmd, bus.data, bus.tx_word}, 0);
        check("arst_ctl", {bus.ch_sel, bus.word_idx, bus.data_strobe}, 0);
        @(posedge clk_sys); #1;
        reset = 1;
        tick();
        check("arst_restart", bus.ch_sel, 1);
        send(16'h0400);
        check("arst_cmd", {bus.cmd_strobe, bus.data_strobe, bus.cmd}, {1'b1, 1'b0, 16'h0400});
        bus.io_en = 0; tick();
        check("arst_fend", bus.frame_end, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
